// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - request FIFO and result register issuing operations to the 4-bit ALU
module alu_op_issue #(
    parameter int DEPTH  = 4,
    parameter int MAX_OP = 3,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_a,
    input  logic [3:0]    in_b,
    input  logic [2:0]    in_op,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [3:0]    alu_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_result,
    output logic [2:0]    out_op,
    output logic          out_err,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [2:0]    MAX_OP_C   = 3'(MAX_OP);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    logic [3:0]    mem_a  [DEPTH];
    logic [3:0]    mem_b  [DEPTH];
    logic [2:0]    mem_op [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          head_err;
    out_state_t    state_q;
    out_state_t    state_d;

    // Handshake and capture qualifiers; full/empty come from count only
    always_comb begin
        fifo_empty = (count == '0);
        in_ready   = (count != FULL_COUNT);
        push       = in_valid && in_ready;
        out_valid  = (state_q == OUT_FULL);
        pop        = !fifo_empty && (!out_valid || out_ready);
        head_err   = (mem_op[rd_ptr] > MAX_OP_C);
    end

    // Head entry drives the ALU; idle FIFO presents zeros
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (!fifo_empty) begin
            alu_a  = mem_a[rd_ptr];
            alu_b  = mem_b[rd_ptr];
            alu_op = mem_op[rd_ptr];
        end
    end

    // Request storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= in_a;
            mem_b[wr_ptr]  <= in_b;
            mem_op[wr_ptr] <= in_op;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register state: becomes FULL on capture, EMPTY when drained with nothing to capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state for the output register
    always_comb begin
        state_d = state_q;
        if (pop) begin
            state_d = OUT_FULL;
        end else if ((state_q == OUT_FULL) && out_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    // Result capture; illegal opcodes report an error with a zero result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_result <= '0;
            out_op     <= '0;
            out_err    <= 1'b0;
        end else if (pop) begin
            out_op <= mem_op[rd_ptr];
            if (head_err) begin
                out_err    <= 1'b1;
                out_result <= '0;
            end else begin
                out_err    <= 1'b0;
                out_result <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - randomized self-checking bench for alu_op_issue with a queue-based model
module tb_alu_op_issue;

    localparam int DEPTH  = 4;
    localparam int MAX_OP = 3;
    localparam int CW     = 3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [2:0] out_op;
    logic       out_err;
    logic [CW-1:0] count;

    int checks;
    int errors;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } req_t;

    req_t       mq[$];
    bit         mv;
    logic [3:0] mres;
    logic [2:0] mop;
    bit         merr;

    // Stand-in for the ALU: add, sub, and, or; anything else xor
    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_a, alu_b, alu_op);

    alu_op_issue #(.DEPTH(DEPTH), .MAX_OP(MAX_OP), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_err    (out_err),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the model applies the same edge to its queue and output slot
    task automatic cycle();
        bit   acc;
        bit   cap;
        req_t h;
        acc = rst_n && in_valid && (mq.size() < DEPTH);
        cap = rst_n && (mq.size() > 0) && (!mv || out_ready);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            mv   = 0;
            mres = '0;
            mop  = '0;
            merr = 0;
        end else begin
            if (cap) begin
                h    = mq.pop_front();
                mv   = 1;
                mop  = h.op;
                merr = (h.op > MAX_OP);
                mres = merr ? 4'd0 : ref_alu(h.a, h.b, h.op);
            end else if (mv && out_ready) begin
                mv = 0;
            end
            if (acc) begin
                h.a  = in_a;
                h.b  = in_b;
                h.op = in_op;
                mq.push_back(h);
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0);
        out_ready = 1;
        for (int i = 0; i < DEPTH + 3; i++) cycle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(0, 0, 0, 0);
        out_ready = 0;
        cycle();
        cycle();
        rst_n = 1;
        cycle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_result !== 4'd0) begin errors++; $display("FAIL reset_out_result got %0d want 0", out_result); end
        checks++; if ({alu_a, alu_b, alu_op} !== 11'd0) begin errors++; $display("FAIL reset_alu got %h/%h/%h want 0/0/0", alu_a, alu_b, alu_op); end
    endtask

    task automatic test_single();
        out_ready = 1;
        drive(1, 4'd1, 4'd1, 3'd0);
        cycle();
        checks++; if (alu_a !== 4'd1) begin errors++; $display("FAIL single_alu_a got %0d want 1", alu_a); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid); end
        drive(0, 0, 0, 0);
        cycle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (out_result !== ref_alu(4'd1, 4'd1, 3'd0)) begin errors++; $display("FAIL single_result got %0d want %0d", out_result, ref_alu(4'd1, 4'd1, 3'd0)); end
        checks++; if (out_op !== 3'd0 || out_err !== 1'b0) begin errors++; $display("FAIL single_op_err got %0d/%b want 0/0", out_op, out_err); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count got %0d want 0", count); end
        drain();
    endtask

    task automatic test_streaming();
        out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1, 4'd1, 4'd1, 3'(k));
            else drive(0, 0, 0, 0);
            cycle();
            if (k >= 1 && k <= 4) begin
                checks++; if (out_valid !== 1'b1 || out_op !== 3'(k - 1)) begin errors++; $display("FAIL stream_%0d got valid=%b op=%0d want valid=1 op=%0d", k, out_valid, out_op, k - 1); end
                checks++; if (out_result !== mres) begin errors++; $display("FAIL stream_result_%0d got %0d want %0d", k, out_result, mres); end
            end else if (k == 5) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got valid=%b want 0", out_valid); end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        req_t r[6];
        out_ready = 0;
        for (int k = 0; k < 6; k++) begin
            r[k] = req_t'($urandom);
            drive(1, r[k].a, r[k].b, r[k].op);
            cycle();
            if (k == 4) begin
                checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got count=%0d ready=%b want 4/0", count, in_ready); end
            end
        end
        checks++; if (count !== 3'd4 || out_valid !== 1'b1 || out_op !== r[0].op) begin errors++; $display("FAIL bp_hold got count=%0d valid=%b op=%0d want 4/1/%0d", count, out_valid, out_op, r[0].op); end
        drive(0, 0, 0, 0);
        out_ready = 1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k == 1) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b want 1", in_ready); end
            end
            if (k <= 4) begin
                checks++; if (out_valid !== 1'b1 || out_op !== r[k].op) begin errors++; $display("FAIL bp_drain_%0d got valid=%b op=%0d want 1/%0d", k, out_valid, out_op, r[k].op); end
                checks++; if (out_result !== ((r[k].op > MAX_OP) ? 4'd0 : ref_alu(r[k].a, r[k].b, r[k].op))) begin errors++; $display("FAIL bp_result_%0d got %0d", k, out_result); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got valid=%b want 0", out_valid); end
            end
        end
        drain();
    endtask

    task automatic test_simultaneous();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 3)));
            cycle();
        end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_setup got count=%0d want 2", count); end
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 3)));
            cycle();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count_%0d got %0d want 2", k, count); end
            checks++; if (out_op !== mop || out_result !== mres) begin errors++; $display("FAIL simul_order_%0d got op=%0d res=%0d want op=%0d res=%0d", k, out_op, out_result, mop, mres); end
        end
        drain();
    endtask

    task automatic test_illegal();
        out_ready = 1;
        drive(1, 4'd3, 4'd2, 3'd5);
        cycle();
        drive(1, 4'd3, 4'd2, 3'd1);
        cycle();
        checks++; if (out_err !== 1'b1 || out_result !== 4'd0 || out_op !== 3'd5) begin errors++; $display("FAIL illegal got err=%b res=%0d op=%0d want 1/0/5", out_err, out_result, out_op); end
        drive(0, 0, 0, 0);
        cycle();
        checks++; if (out_err !== 1'b0 || out_result !== 4'd1 || out_op !== 3'd1) begin errors++; $display("FAIL legal_after got err=%b res=%0d op=%0d want 0/1/1", out_err, out_result, out_op); end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 3)));
            cycle();
        end
        checks++; if (count !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL midrst_setup got count=%0d valid=%b want 3/1", count, out_valid); end
        drive(0, 0, 0, 0);
        rst_n = 0;
        cycle();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst got count=%0d valid=%b want 0/0", count, out_valid); end
        rst_n = 1;
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL midrst_stale_%0d got valid=%b count=%0d want 0/0", k, out_valid, count); end
        end
    endtask

    task automatic test_random();
        logic [3:0] ea;
        logic [3:0] eb;
        logic [2:0] eo;
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 3'($urandom));
            cycle();
            ea = (mq.size() > 0) ? mq[0].a  : 4'd0;
            eb = (mq.size() > 0) ? mq[0].b  : 4'd0;
            eo = (mq.size() > 0) ? mq[0].op : 3'd0;
            checks++; if (count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rand_fifo_%0d got count=%0d ready=%b want %0d/%b", n, count, in_ready, mq.size(), mq.size() < DEPTH); end
            checks++; if ({alu_a, alu_b, alu_op} !== {ea, eb, eo}) begin errors++; $display("FAIL rand_alu_%0d got %h/%h/%h want %h/%h/%h", n, alu_a, alu_b, alu_op, ea, eb, eo); end
            checks++; if (out_valid !== mv || out_result !== mres || out_op !== mop || out_err !== merr) begin errors++; $display("FAIL rand_out_%0d got v=%b r=%0d o=%0d e=%b want v=%b r=%0d o=%0d e=%b", n, out_valid, out_result, out_op, out_err, mv, mres, mop, merr); end
        end
        rst_n = 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        out_ready = 0;
        drive(0, 0, 0, 0);
        mv = 0; mres = '0; mop = '0; merr = 0;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
